// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - RV32IM decode to ALU control/operands behind a two-entry skid buffer
// Main entry drives the ALU; the skid entry absorbs one extra instruction while main is stalled.
module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [31:0]     i_in_instr,
  input  logic [XLEN-1:0] i_in_pc,
  input  logic [XLEN-1:0] i_in_rs1,
  input  logic [XLEN-1:0] i_in_rs2,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_out_l,
  output logic [XLEN-1:0] o_out_r,
  output logic [4:0]      o_out_control,
  output logic [4:0]      o_out_rd,
  output logic [XLEN-1:0] o_out_pc,
  output logic            o_out_illegal
);

  localparam logic [4:0] C_ADD = 5'd0,  C_SUB = 5'd1,  C_AND = 5'd2,  C_OR = 5'd3;
  localparam logic [4:0] C_XOR = 5'd4,  C_SRA = 5'd7,  C_SRL = 5'd8,  C_SLL = 5'd9;
  localparam logic [4:0] C_MUL = 5'd10, C_LUI = 5'd11, C_EQ = 5'd12,  C_NE = 5'd13;
  localparam logic [4:0] C_SLT = 5'd14, C_SGE = 5'd15, C_SLTU = 5'd16, C_SGEU = 5'd17;
  localparam logic [4:0] C_ILL = 5'd31;

  localparam logic [6:0] OP_OP = 7'b0110011, OP_IMM = 7'b0010011, OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111, OP_BR = 7'b1100011, OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [31:0]     w_i_imm;
  logic [31:0]     w_s_imm;
  logic [31:0]     w_u_imm;
  logic [4:0]      w_ctrl;
  logic [XLEN-1:0] w_l;
  logic [XLEN-1:0] w_r;
  logic            w_ill;
  logic            w_unused;

  assign w_opc    = i_in_instr[6:0];
  assign w_f3     = i_in_instr[14:12];
  assign w_f7     = i_in_instr[31:25];
  assign w_i_imm  = {{20{i_in_instr[31]}}, i_in_instr[31:20]};
  assign w_s_imm  = {{20{i_in_instr[31]}}, i_in_instr[31:25], i_in_instr[11:7]};
  assign w_u_imm  = {i_in_instr[31:12], 12'b0};
  assign w_unused = &{1'b0, i_in_instr[19:15]};

  function automatic logic [4:0] f3_code(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  f3_code = C_ADD;
      3'b001:  f3_code = C_SLL;
      3'b010:  f3_code = C_SLT;
      3'b011:  f3_code = C_SLTU;
      3'b100:  f3_code = C_XOR;
      3'b101:  f3_code = alt ? C_SRA : C_SRL;
      3'b110:  f3_code = C_OR;
      default: f3_code = C_AND;
    endcase
  endfunction

  always_comb begin
    w_ctrl = C_ILL;
    w_l    = '0;
    w_r    = '0;
    w_ill  = 1'b0;
    case (w_opc)
      OP_OP: begin
        w_l = i_in_rs1;
        w_r = i_in_rs2;
        if (w_f7 == 7'b0000000)
          w_ctrl = f3_code(w_f3, 1'b0);
        else if (w_f7 == 7'b0100000 && w_f3 == 3'b000)
          w_ctrl = C_SUB;
        else if (w_f7 == 7'b0100000 && w_f3 == 3'b101)
          w_ctrl = C_SRA;
        else if (w_f7 == 7'b0000001 && w_f3 == 3'b000)
          w_ctrl = C_MUL;
        else
          w_ill = 1'b1;
      end
      OP_IMM: begin
        w_l    = i_in_rs1;
        w_r    = w_i_imm;
        w_ctrl = f3_code(w_f3, i_in_instr[30]);
      end
      OP_LUI: begin
        w_ctrl = C_LUI;
        w_r    = {12'b0, i_in_instr[31:12]};
      end
      OP_AUIPC: begin
        w_ctrl = C_ADD;
        w_l    = i_in_pc;
        w_r    = w_u_imm;
      end
      OP_BR: begin
        w_l = i_in_rs1;
        w_r = i_in_rs2;
        case (w_f3)
          3'b000:  w_ctrl = C_EQ;
          3'b001:  w_ctrl = C_NE;
          3'b100:  w_ctrl = C_SLT;
          3'b101:  w_ctrl = C_SGE;
          3'b110:  w_ctrl = C_SLTU;
          3'b111:  w_ctrl = C_SGEU;
          default: w_ill  = 1'b1;
        endcase
      end
      OP_LOAD: begin
        w_ctrl = C_ADD;
        w_l    = i_in_rs1;
        w_r    = w_i_imm;
      end
      OP_STORE: begin
        w_ctrl = C_ADD;
        w_l    = i_in_rs1;
        w_r    = w_s_imm;
      end
      OP_JAL, OP_JALR: begin
        w_ctrl = C_ADD;
        w_l    = i_in_pc;
        w_r    = 32'd4;
      end
      default: w_ill = 1'b1;
    endcase
    // Illegal entries still flow downstream, but with inert operands.
    if (w_ill) begin
      w_ctrl = C_ILL;
      w_l    = '0;
      w_r    = '0;
    end
  end

  logic            r_m_valid;
  logic [XLEN-1:0] r_m_l, r_m_r, r_m_pc;
  logic [4:0]      r_m_ctrl, r_m_rd;
  logic            r_m_ill;
  logic            r_s_valid;
  logic [XLEN-1:0] r_s_l, r_s_r, r_s_pc;
  logic [4:0]      r_s_ctrl, r_s_rd;
  logic            r_s_ill;
  logic            r_in_ready;
  logic            w_accept;
  logic            w_consume;

  assign w_accept  = i_in_valid & r_in_ready;
  assign w_consume = r_m_valid & i_out_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_m_valid  <= 1'b0;
      r_m_l      <= '0;
      r_m_r      <= '0;
      r_m_pc     <= '0;
      r_m_ctrl   <= '0;
      r_m_rd     <= '0;
      r_m_ill    <= 1'b0;
      r_s_valid  <= 1'b0;
      r_s_l      <= '0;
      r_s_r      <= '0;
      r_s_pc     <= '0;
      r_s_ctrl   <= '0;
      r_s_rd     <= '0;
      r_s_ill    <= 1'b0;
      r_in_ready <= 1'b1;
    end else if (i_flush) begin
      r_m_valid  <= 1'b0;
      r_s_valid  <= 1'b0;
      r_in_ready <= 1'b1;
    end else if (!r_m_valid || w_consume) begin
      // in_ready is low whenever skid is full, so no accept competes with the skid move.
      if (r_s_valid) begin
        r_m_l      <= r_s_l;
        r_m_r      <= r_s_r;
        r_m_pc     <= r_s_pc;
        r_m_ctrl   <= r_s_ctrl;
        r_m_rd     <= r_s_rd;
        r_m_ill    <= r_s_ill;
        r_s_valid  <= 1'b0;
        r_in_ready <= 1'b1;
      end else if (w_accept) begin
        r_m_valid <= 1'b1;
        r_m_l     <= w_l;
        r_m_r     <= w_r;
        r_m_pc    <= i_in_pc;
        r_m_ctrl  <= w_ctrl;
        r_m_rd    <= i_in_instr[11:7];
        r_m_ill   <= w_ill;
      end else begin
        r_m_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_s_valid  <= 1'b1;
      r_s_l      <= w_l;
      r_s_r      <= w_r;
      r_s_pc     <= i_in_pc;
      r_s_ctrl   <= w_ctrl;
      r_s_rd     <= i_in_instr[11:7];
      r_s_ill    <= w_ill;
      r_in_ready <= 1'b0;
    end
  end

  assign o_in_ready    = r_in_ready;
  assign o_out_valid   = r_m_valid;
  assign o_out_l       = r_m_l;
  assign o_out_r       = r_m_r;
  assign o_out_control = r_m_ctrl;
  assign o_out_rd      = r_m_rd;
  assign o_out_pc      = r_m_pc;
  assign o_out_illegal = r_m_ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed vector bench for alu_issue_stage
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr, in_pc, in_rs1, in_rs2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_l, out_r, out_pc;
  logic [4:0]  out_control, out_rd;
  logic        out_illegal;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_instr(in_instr), .i_in_pc(in_pc), .i_in_rs1(in_rs1), .i_in_rs2(in_rs2),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_l(out_l), .o_out_r(out_r), .o_out_control(out_control),
    .o_out_rd(out_rd), .o_out_pc(out_pc), .o_out_illegal(out_illegal)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  ctrl;
    logic [31:0] l;
    logic [31:0] r;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0; in_rs1 = 32'd5; in_rs2 = 32'd7;

    // rs1 = 5, rs2 = 7 throughout the vector table
    vecs.push_back('{"add",    32'h002081B3, 32'h000, 5'd0,  32'd5,     32'd7,        1'b0});
    vecs.push_back('{"sub",    32'h402081B3, 32'h004, 5'd1,  32'd5,     32'd7,        1'b0});
    vecs.push_back('{"mul",    32'h022081B3, 32'h008, 5'd10, 32'd5,     32'd7,        1'b0});
    vecs.push_back('{"srl",    32'h003150B3, 32'h00C, 5'd8,  32'd5,     32'd7,        1'b0});
    vecs.push_back('{"sltu",   32'h0020B0B3, 32'h010, 5'd16, 32'd5,     32'd7,        1'b0});
    vecs.push_back('{"op_bad", 32'h402091B3, 32'h014, 5'd31, 32'd0,     32'd0,        1'b1});
    vecs.push_back('{"addi",   32'hFFF00093, 32'h018, 5'd0,  32'd5,     32'hFFFFFFFF, 1'b0});
    vecs.push_back('{"srai",   32'h4040D093, 32'h01C, 5'd7,  32'd5,     32'h00000404, 1'b0});
    vecs.push_back('{"xori",   32'h0F014093, 32'h020, 5'd4,  32'd5,     32'h000000F0, 1'b0});
    vecs.push_back('{"lui",    32'h123450B7, 32'h024, 5'd11, 32'd0,     32'h00012345, 1'b0});
    vecs.push_back('{"auipc",  32'h00001097, 32'h100, 5'd0,  32'h100,   32'h00001000, 1'b0});
    vecs.push_back('{"beq",    32'h00208063, 32'h104, 5'd12, 32'd5,     32'd7,        1'b0});
    vecs.push_back('{"bltu",   32'h0020E063, 32'h108, 5'd16, 32'd5,     32'd7,        1'b0});
    vecs.push_back('{"bge",    32'h0020D063, 32'h10C, 5'd15, 32'd5,     32'd7,        1'b0});
    vecs.push_back('{"bgeu",   32'h0020F063, 32'h110, 5'd17, 32'd5,     32'd7,        1'b0});
    vecs.push_back('{"br_bad", 32'h0020A063, 32'h114, 5'd31, 32'd0,     32'd0,        1'b1});
    vecs.push_back('{"lw",     32'hFFC12083, 32'h118, 5'd0,  32'd5,     32'hFFFFFFFC, 1'b0});
    vecs.push_back('{"sw",     32'h0020A423, 32'h11C, 5'd0,  32'd5,     32'd8,        1'b0});
    vecs.push_back('{"jal",    32'h0000006F, 32'h040, 5'd0,  32'h040,   32'd4,        1'b0});
    vecs.push_back('{"jalr",   32'h00008067, 32'h200, 5'd0,  32'h200,   32'd4,        1'b0});
    vecs.push_back('{"op7f",   32'h0000007F, 32'h204, 5'd31, 32'd0,     32'd0,        1'b1});

    #2;
    chk("rst_valid",   {31'b0, out_valid},   32'd0);
    chk("rst_ready",   {31'b0, in_ready},    32'd1);
    chk("rst_ctrl",    {27'b0, out_control}, 32'd0);
    chk("rst_illegal", {31'b0, out_illegal}, 32'd0);
    chk("rst_l",       out_l,                32'd0);
    @(negedge clk);
    rst = 1'b0;

    // back-to-back stream with out_ready held high
    foreach (vecs[i]) begin
      drive(vecs[i].instr, vecs[i].pc);
      after_edge();
      chk({vecs[i].name, "_valid"}, {31'b0, out_valid},   32'd1);
      chk({vecs[i].name, "_ready"}, {31'b0, in_ready},    32'd1);
      chk({vecs[i].name, "_ctrl"},  {27'b0, out_control}, {27'b0, vecs[i].ctrl});
      chk({vecs[i].name, "_l"},     out_l,                vecs[i].l);
      chk({vecs[i].name, "_r"},     out_r,                vecs[i].r);
      chk({vecs[i].name, "_pc"},    out_pc,               vecs[i].pc);
      chk({vecs[i].name, "_ill"},   {31'b0, out_illegal}, {31'b0, vecs[i].ill});
    end
    chk("add_rd_field", {27'b0, out_rd}, 32'd0);
    @(negedge clk); in_valid = 1'b0;
    after_edge();
    chk("drain_valid", {31'b0, out_valid}, 32'd0);

    // stall: A to main, B to skid, C held upstream
    @(negedge clk); out_ready = 1'b0;
    drive(32'h002081B3, 32'hA00);
    after_edge();
    chk("stall_a_valid", {31'b0, out_valid}, 32'd1);
    chk("stall_a_rd",    {27'b0, out_rd},    32'd3);
    drive(32'h402081B3, 32'hB00);
    after_edge();
    chk("stall_skid_ready", {31'b0, in_ready}, 32'd0);
    chk("stall_a_held",     out_pc,            32'hA00);
    drive(32'h0020F1B3, 32'hC00);
    after_edge();
    chk("stall_c_blocked", {31'b0, in_ready}, 32'd0);
    chk("stall_a_stable",  {27'b0, out_control}, 32'd0);
    @(negedge clk); out_ready = 1'b1;
    after_edge();
    chk("release_b_pc",    out_pc,               32'hB00);
    chk("release_b_ctrl",  {27'b0, out_control}, 32'd1);
    chk("release_ready",   {31'b0, in_ready},    32'd1);
    after_edge();
    chk("release_c_pc",    out_pc,               32'hC00);
    chk("release_c_ctrl",  {27'b0, out_control}, 32'd2);
    @(negedge clk); in_valid = 1'b0;
    after_edge();
    chk("release_empty",   {31'b0, out_valid},   32'd0);

    // flush with skid full; upstream C offered but blocked
    @(negedge clk); out_ready = 1'b0;
    drive(32'h002081B3, 32'hA10);
    drive(32'h402081B3, 32'hB10);
    drive(32'h0020F1B3, 32'hC10);
    flush = 1'b1;
    after_edge();
    chk("flush_full_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_full_ready", {31'b0, in_ready},  32'd1);

    // flush coinciding with an accept: the accepted D must vanish
    @(negedge clk); flush = 1'b0; in_instr = 32'h002081B3; in_pc = 32'hA20;
    after_edge();
    chk("flush2_a_pc", out_pc, 32'hA20);
    @(negedge clk); flush = 1'b1; in_instr = 32'h0020E063; in_pc = 32'hD20;
    after_edge();
    chk("flush2_valid", {31'b0, out_valid}, 32'd0);
    chk("flush2_ready", {31'b0, in_ready},  32'd1);
    @(negedge clk); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    after_edge();
    chk("flush2_no_ghost", {31'b0, out_valid}, 32'd0);

    // async reset in the middle of a stall
    @(negedge clk); out_ready = 1'b0;
    drive(32'h0020F1B3, 32'hA30);
    drive(32'h402081B3, 32'hB30);
    after_edge();
    chk("prerst_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk); in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, out_valid},   32'd0);
    chk("arst_ready", {31'b0, in_ready},    32'd1);
    chk("arst_ctrl",  {27'b0, out_control}, 32'd0);
    chk("arst_pc",    out_pc,               32'd0);
    @(negedge clk); rst = 1'b0; out_ready = 1'b1;
    drive(32'h00001097, 32'h300);
    after_edge();
    chk("postrst_pc", out_pc, 32'h300);
    chk("postrst_l",  out_l,  32'h300);
    @(negedge clk); in_valid = 1'b0;
    after_edge();
    chk("postrst_empty", {31'b0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
